uart_rx_param: RTL

Parametrised UART receiver, successor to the fixed 8N1 460.8 kbaud receiver.
- Adds: generic baud divisor, data width, optional parity, 1 or 2 stop bits, mid-bit start-glitch rejection, stop/parity error detection, and a valid/ready output handshake with overrun flag.
- Sits between the serial pin and the audio sample assembly logic, on the CLOCK_50 domain.

---
 rtl/uart_rx_param_pkg.sv | 22 ++
 rtl/uart_rx_param_bit_timer.sv | 37 +++
 rtl/uart_rx_param.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/uart_rx_param_pkg.sv
// Shared types and helpers for the parametrised UART receiver and its bit timer.
// The bit timer is intended to be reused by the matching transmitter.
package uart_rx_param_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_PARITY    = 3'd3,
    S_STOP      = 3'd4,
    S_WAIT_IDLE = 3'd5
  } rx_state_t;

  localparam logic PARITY_MODE_EVEN = 1'b0;
  localparam logic PARITY_MODE_ODD  = 1'b1;

  // Counter width helper; never returns less than one bit.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/uart_rx_param_bit_timer.sv
// Loadable bit-period down-counter: half-period load for start-bit centring,
// full-period load/auto-reload for every following bit, 1-cycle tick at zero.
module uart_rx_param_bit_timer
  import uart_rx_param_pkg::*;
#(
  parameter int CLKS_PER_BIT = 108
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_load_half,
  input  logic i_load_full,
  output logic o_tick
);

  localparam int CNT_W = clog2_min1(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] C_HALF = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == '0);

  // Reloading the full period on every tick keeps successive samples one bit apart.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load_half) begin
      r_cnt <= C_HALF;
    end else if (i_load_full) begin
      r_cnt <= C_FULL;
    end else if (i_en) begin
      r_cnt <= (r_cnt == '0) ? C_FULL : r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchronised input, mid-bit sampling, optional parity,
// 1 or 2 stop bits, error pulses and a valid/ready output with overrun detection.
module uart_rx_param
  import uart_rx_param_pkg::*;
#(
  parameter int CLKS_PER_BIT = 108,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 CLOCK_50,
  input  logic                 Reset,
  input  logic                 Serial_In,
  output logic [DATA_BITS-1:0] Data_Out,
  output logic                 Data_Valid,
  input  logic                 Data_Ready,
  output logic                 Busy,
  output logic                 Framing_Error,
  output logic                 Parity_Error,
  output logic                 Overrun_Error
);

  localparam int CNT_W = 4;
  localparam logic C_PAR_ODD = (PARITY_ODD != 0) ? PARITY_MODE_ODD : PARITY_MODE_EVEN;
  localparam logic [CNT_W-1:0] C_LAST_DATA = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] C_LAST_STOP = CNT_W'(STOP_BITS - 1);
  localparam rx_state_t C_AFTER_DATA = (PARITY_EN != 0) ? S_PARITY : S_STOP;

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_rx_d;
  rx_state_t            r_state;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data_out;
  logic                 r_par_err;
  logic                 r_frame_done;
  logic                 r_valid;
  logic                 r_fe;
  logic                 r_pe;
  logic                 r_ovr;

  logic w_fall;
  logic w_tick;
  logic w_en;
  logic w_load_half;
  logic w_load_full;

  // Synchroniser and edge history reset high so reset release never looks like a start edge.
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_rx_d  <= 1'b1;
    end else begin
      r_sync1 <= Serial_In;
      r_sync2 <= r_sync1;
      r_rx_d  <= r_sync2;
    end
  end

  assign w_fall      = r_rx_d & ~r_sync2;
  assign w_en        = (r_state == S_START) || (r_state == S_DATA) ||
                       (r_state == S_PARITY) || (r_state == S_STOP);
  assign w_load_half = (r_state == S_IDLE) && w_fall;
  assign w_load_full = (r_state == S_START) && w_tick && !r_sync2;

  uart_rx_param_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .i_clk      (CLOCK_50),
    .i_rst      (Reset),
    .i_en       (w_en),
    .i_load_half(w_load_half),
    .i_load_full(w_load_full),
    .o_tick     (w_tick)
  );

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      r_state      <= S_IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_par_err    <= 1'b0;
      r_frame_done <= 1'b0;
      r_fe         <= 1'b0;
      r_pe         <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_fe         <= 1'b0;
      r_pe         <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_fall) r_state <= S_START;
        end
        S_START: begin
          if (w_tick) begin
            if (r_sync2) begin
              r_state <= S_IDLE;
            end else begin
              r_bit_cnt <= '0;
              r_par_err <= 1'b0;
              r_state   <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_shift <= {r_sync2, r_shift[DATA_BITS-1:1]};
            if (r_bit_cnt == C_LAST_DATA) begin
              r_bit_cnt <= '0;
              r_state   <= C_AFTER_DATA;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (w_tick) begin
            r_par_err <= ((^r_shift) ^ r_sync2) != C_PAR_ODD;
            r_state   <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_tick) begin
            if (!r_sync2) begin
              r_fe    <= 1'b1;
              r_state <= S_WAIT_IDLE;
            end else if (r_bit_cnt == C_LAST_STOP) begin
              // Leaving at mid-stop re-arms IDLE in time for a back-to-back start edge.
              r_pe         <= r_par_err;
              r_frame_done <= !r_par_err;
              r_state      <= S_IDLE;
            end else begin
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        S_WAIT_IDLE: begin
          if (r_sync2) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Output holding register: an accept in the completion cycle frees the slot for the new word.
  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      r_data_out <= '0;
      r_valid    <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      r_ovr <= 1'b0;
      if (r_frame_done) begin
        if (!r_valid || Data_Ready) begin
          r_data_out <= r_shift;
          r_valid    <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (r_valid && Data_Ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign Data_Out      = r_data_out;
  assign Data_Valid    = r_valid;
  assign Busy          = (r_state != S_IDLE);
  assign Framing_Error = r_fe;
  assign Parity_Error  = r_pe;
  assign Overrun_Error = r_ovr;

endmodule
